uart_reg_arbiter: RTL and testbench
===================================

// Module: uart_reg_arbiter
// PURPOSE
//  Shares the single uart_top register port between two requesters (m0 = core LSU, m1 = debug/DMA).
//  Round-robin grant, one transaction at a time.
//  Full 4-phase en/ready handshake on both sides: requester holds en until ready, drops en, then ready drops.
//  Sits between the peripheral bus decoder and uart_top; data_ready_int is mirrored to both requesters.
// PARAMETERS
//  ADDR_W          32    register address width
//  DATA_W          32    register data width
//  TIMEOUT_CYCLES  1024  ISSUE-state watchdog limit (used only with UART_ARB_TIMEOUT_EN)
// PORTS
//  clk             in   1       system clock, rising edge
//  rst             in   1       asynchronous reset, active-high
//  m0_wr_en        in   1       m0 write request
//  m0_rd_en        in   1       m0 read request
//  m0_addr         in   ADDR_W  m0 register offset (00 cfg, 04 data, 08 status)
//  m0_wdata        in   DATA_W  m0 write data
//  m0_rdata        out  DATA_W  m0 read data, valid while m0_ready=1
//  m0_ready        out  1       m0 handshake acknowledge
//  m0_int          out  1       copy of uart_data_ready_int
//  m1_*            --   --      identical set for requester m1
//  uart_reg_wr_en  out  1       to uart_top
//  uart_reg_rd_en  out  1       to uart_top
//  uart_reg_addr   out  ADDR_W  to uart_top
//  uart_reg_wdata  out  DATA_W  to uart_top
//  uart_reg_rdata  in   DATA_W  from uart_top
//  uart_ready      in   1       from uart_top
//  uart_data_ready_int  in  1   from uart_top
//  arb_err         out  1       timeout flag (tied 0 without UART_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; last_grant=1, so m0 wins the first tie.
//  Reset is honoured mid-transaction: uart en drops immediately and no completion is signalled.
//  Request: mN_req = mN_wr_en | mN_rd_en. If wr_en and rd_en are both set, the transaction is a write.
//  IDLE:
//   - no request -> stay IDLE.
//   - exactly one request -> grant that requester.
//   - both request -> grant ~last_grant.
//   - On grant, register addr, wdata and op; drive the selected uart_reg_*_en=1 next cycle; -> ISSUE.
//   - Latency from request to uart en: 1 cycle.
//  ISSUE:
//   - Hold uart en, addr and wdata stable until uart_ready=1.
//   - On that edge: capture uart_reg_rdata into mG_rdata (writes capture too); set mG_ready=1; clear uart en; -> RELEASE.
//  RELEASE:
//   - Wait until uart_ready=0 AND mG_wr_en=0 AND mG_rd_en=0.
//   - Then clear mG_ready; set last_grant=G; -> IDLE.
//   - At least 1 idle cycle between transactions.
//  A requester dropping en during ISSUE does not abort: the UART transaction completes, ready still pulses.
//  Ungranted requester: its ready stays 0 and its request is held pending; no starvation (RR alternates).
//  mN_rdata holds its last captured value until the next completion to that requester.
//  mN_int = uart_data_ready_int combinationally, for both N.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined:
//   - Counter cleared on entering ISSUE, counts each ISSUE cycle.
//   - Reaching TIMEOUT_CYCLES with no uart_ready: clear uart en; mG_rdata=32'hDEAD_BEEF; mG_ready=1; arb_err=1 (sticky until rst); -> RELEASE.
//  UART_ARB_TIMEOUT_EN not defined: no counter; ISSUE waits indefinitely; arb_err=0.
// TESTING
//  1. m0 writes 32'h2_3C1B to addr 00, uart_ready after 3 cycles
//     -> uart_reg_wr_en high 1 cycle after request; m0_ready rises; m1_ready stays 0.
//  2. m0 and m1 request in the same cycle, repeated 4 times
//     -> grants m0,m1,m0,m1; uart addr/wdata match the grantee each time.
//  3. m1 reads addr 08, uart_reg_rdata=32'h0000_0001 -> m1_rdata=1 while m1_ready=1; m0_rdata unchanged.
//  4. m0 asserts wr_en and rd_en together -> only uart_reg_wr_en asserted.
//  5. rst pulse while in ISSUE -> all outputs 0 next edge; next simultaneous request granted to m0.
//  6. [UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16] uart_ready held 0
//     -> after 16 ISSUE cycles m0_ready=1, m0_rdata=32'hDEAD_BEEF, arb_err=1.

Source files
------------

// File: rtl/uart_reg_arbiter.sv
// uart_reg_arbiter
//
// Shares the single uart_top register port between two requesters:
// m0 (core LSU) and m1 (debug/DMA). Grants are round-robin and only one
// transaction is in flight at a time. Both sides use a full 4-phase
// en/ready handshake: the requester holds en until ready, drops en, and
// then ready drops.
//
// Ports
//   clk, rst              system clock (rising edge), asynchronous active-high reset
//   mN_wr_en, mN_rd_en    requester N write / read request (both set = write)
//   mN_addr, mN_wdata     requester N register offset and write data
//   mN_rdata              requester N read data, valid while mN_ready=1, held afterwards
//   mN_ready              requester N handshake acknowledge
//   mN_int                combinational copy of uart_data_ready_int
//   uart_reg_*            register port towards uart_top
//   uart_ready            uart_top handshake acknowledge
//   uart_data_ready_int   uart_top data-ready interrupt
//   arb_err               sticky watchdog timeout flag
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   When defined, an ISSUE-state watchdog completes a stuck transaction after
//   TIMEOUT_CYCLES cycles with read data 32'hDEAD_BEEF and sets arb_err.
//   When undefined, ISSUE waits indefinitely and arb_err is tied to 0.

module uart_reg_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_wr_en,
    input  logic              m0_rd_en,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    output logic              m0_int,

    input  logic              m1_wr_en,
    input  logic              m1_rd_en,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              m1_int,

    output logic              uart_reg_wr_en,
    output logic              uart_reg_rd_en,
    output logic [ADDR_W-1:0] uart_reg_addr,
    output logic [DATA_W-1:0] uart_reg_wdata,
    input  logic [DATA_W-1:0] uart_reg_rdata,
    input  logic              uart_ready,
    input  logic              uart_data_ready_int,

    output logic              arb_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]        state;
    logic              grant;
    logic              last_grant;
    logic              m0_req;
    logic              m1_req;
    logic              pick;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              grant_req;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] timeout_cnt;
`else
    assign arb_err = 1'b0;
`endif

    assign m0_req = m0_wr_en | m0_rd_en;
    assign m1_req = m1_wr_en | m1_rd_en;

    assign m0_int = uart_data_ready_int;
    assign m1_int = uart_data_ready_int;

    // A tie goes to whoever was not served last; a lone requester wins outright.
    // The request mux follows the candidate winner so the IDLE branch can
    // register it directly. A request with both enables set is a write.
    always_comb begin
        pick      = (m0_req && m1_req) ? ~last_grant : m1_req;
        sel_wr    = pick ? m1_wr_en : m0_wr_en;
        sel_addr  = pick ? m1_addr  : m0_addr;
        sel_wdata = pick ? m1_wdata : m0_wdata;
        grant_req = grant ? m1_req : m0_req;
    end

    // Single transaction engine: IDLE registers the winning request, ISSUE
    // holds the uart side stable until uart_ready, RELEASE waits for both
    // the uart and the granted requester to finish their 4-phase handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            grant          <= 1'b0;
            last_grant     <= 1'b1;
            uart_reg_wr_en <= 1'b0;
            uart_reg_rd_en <= 1'b0;
            uart_reg_addr  <= '0;
            uart_reg_wdata <= '0;
            m0_rdata       <= '0;
            m1_rdata       <= '0;
            m0_ready       <= 1'b0;
            m1_ready       <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_cnt    <= '0;
            arb_err        <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        grant          <= pick;
                        uart_reg_wr_en <= sel_wr;
                        uart_reg_rd_en <= ~sel_wr;
                        uart_reg_addr  <= sel_addr;
                        uart_reg_wdata <= sel_wdata;
`ifdef UART_ARB_TIMEOUT_EN
                        timeout_cnt    <= '0;
`endif
                        state          <= ST_ISSUE;
                    end
                end

                // Completion does not depend on the requester still holding en.
                ST_ISSUE: begin
                    if (uart_ready) begin
                        if (grant) begin
                            m1_rdata <= uart_reg_rdata;
                            m1_ready <= 1'b1;
                        end else begin
                            m0_rdata <= uart_reg_rdata;
                            m0_ready <= 1'b1;
                        end
                        uart_reg_wr_en <= 1'b0;
                        uart_reg_rd_en <= 1'b0;
                        state          <= ST_RELEASE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    // The counter holds the number of ISSUE cycles already
                    // spent, so this fires at the end of the TIMEOUT_CYCLES-th one.
                    else if (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        if (grant) begin
                            m1_rdata <= DATA_W'(32'hDEAD_BEEF);
                            m1_ready <= 1'b1;
                        end else begin
                            m0_rdata <= DATA_W'(32'hDEAD_BEEF);
                            m0_ready <= 1'b1;
                        end
                        uart_reg_wr_en <= 1'b0;
                        uart_reg_rd_en <= 1'b0;
                        arb_err        <= 1'b1;
                        state          <= ST_RELEASE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
`endif
                end

                ST_RELEASE: begin
                    if (!uart_ready && !grant_req) begin
                        m0_ready   <= 1'b0;
                        m1_ready   <= 1'b0;
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_arbiter.sv
// tb_uart_reg_arbiter
//
// Directed bench for uart_reg_arbiter. Stimulus pushes the expected uart-side
// issue (address, data, operation) and the expected completion (which
// requester, captured read data) into queues; two monitors pop and compare
// whenever the DUT raises uart en or a requester ready. A small uart_top
// responder answers each transaction after a programmable delay.

module tb_uart_reg_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              m0_wr_en, m0_rd_en, m0_ready, m0_int;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_wr_en, m1_rd_en, m1_ready, m1_int;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic              uart_reg_wr_en, uart_reg_rd_en;
    logic [ADDR_W-1:0] uart_reg_addr;
    logic [DATA_W-1:0] uart_reg_wdata, uart_reg_rdata;
    logic              uart_ready, uart_data_ready_int;
    logic              arb_err;

    uart_reg_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m0_wr_en(m0_wr_en),
        .m0_rd_en(m0_rd_en),
        .m0_addr(m0_addr),
        .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata),
        .m0_ready(m0_ready),
        .m0_int(m0_int),
        .m1_wr_en(m1_wr_en),
        .m1_rd_en(m1_rd_en),
        .m1_addr(m1_addr),
        .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata),
        .m1_ready(m1_ready),
        .m1_int(m1_int),
        .uart_reg_wr_en(uart_reg_wr_en),
        .uart_reg_rd_en(uart_reg_rd_en),
        .uart_reg_addr(uart_reg_addr),
        .uart_reg_wdata(uart_reg_wdata),
        .uart_reg_rdata(uart_reg_rdata),
        .uart_ready(uart_ready),
        .uart_data_ready_int(uart_data_ready_int),
        .arb_err(arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic        rd;
    } issue_t;

    typedef struct {
        logic        who;
        logic [31:0] rdata;
    } cmp_t;

    issue_t      issueQ[$];
    cmp_t        cmpQ[$];
    int          testsRun    = 0;
    int          testsFailed = 0;
    int          respDelay   = 1;
    logic [31:0] respData    = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        testsRun++;
        if (actual !== required) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, required, $time);
        end
    endtask

    function automatic logic readyOf(input bit m);
        return m ? m1_ready : m0_ready;
    endfunction

    // One full 4-phase transaction from requester m; caller is at a negedge.
    task automatic applyStimulus(input bit m, input logic wr, input logic rd,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        if (m) begin
            m1_wr_en = wr; m1_rd_en = rd; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_wr_en = wr; m0_rd_en = rd; m0_addr = addr; m0_wdata = wdata;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!readyOf(m) && n < 200);
        checkOutput(m ? "m1_ready_seen" : "m0_ready_seen", {31'd0, readyOf(m)}, 32'd1);
        if (m) begin
            m1_wr_en = 1'b0; m1_rd_en = 1'b0;
        end else begin
            m0_wr_en = 1'b0; m0_rd_en = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (readyOf(m) && n < 20);
        checkOutput(m ? "m1_ready_drop" : "m0_ready_drop", {31'd0, readyOf(m)}, 32'd0);
    endtask

    // uart_top stand-in: ready after respDelay cycles of en, drops once en drops.
    initial begin
        int cnt;
        cnt = 0;
        uart_ready = 1'b0;
        uart_reg_rdata = '0;
        forever begin
            @(negedge clk);
            if (uart_reg_wr_en || uart_reg_rd_en) begin
                if (!uart_ready) begin
                    cnt++;
                    if (cnt >= respDelay) begin
                        uart_ready = 1'b1;
                        uart_reg_rdata = respData;
                    end
                end
            end else begin
                uart_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // Issue monitor: every rising uart en must match the next expected issue.
    initial begin
        logic prevEn, curEn;
        issue_t e;
        prevEn = 1'b0;
        forever begin
            @(negedge clk);
            curEn = uart_reg_wr_en | uart_reg_rd_en;
            if (curEn && !prevEn) begin
                if (issueQ.size() == 0) begin
                    checkOutput("issue_unexpected", 32'd1, 32'd0);
                end else begin
                    e = issueQ.pop_front();
                    checkOutput("issue_addr", uart_reg_addr, e.addr);
                    checkOutput("issue_wdata", uart_reg_wdata, e.wdata);
                    checkOutput("issue_wr_en", {31'd0, uart_reg_wr_en}, {31'd0, e.wr});
                    checkOutput("issue_rd_en", {31'd0, uart_reg_rd_en}, {31'd0, e.rd});
                end
            end
            prevEn = curEn;
        end
    end

    // Completion monitor: every rising requester ready must match the next expected completion.
    initial begin
        logic prev0, prev1;
        cmp_t e;
        prev0 = 1'b0;
        prev1 = 1'b0;
        forever begin
            @(negedge clk);
            if ((m0_ready && !prev0) || (m1_ready && !prev1)) begin
                if (cmpQ.size() == 0) begin
                    checkOutput("cmp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = cmpQ.pop_front();
                    checkOutput("cmp_who", {31'd0, m1_ready}, {31'd0, e.who});
                    checkOutput("cmp_other_ready", {31'd0, e.who ? m0_ready : m1_ready}, 32'd0);
                    checkOutput("cmp_rdata", e.who ? m1_rdata : m0_rdata, e.rdata);
                end
            end
            prev0 = m0_ready;
            prev1 = m1_ready;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        m0_wr_en = 0; m0_rd_en = 0; m0_addr = '0; m0_wdata = '0;
        m1_wr_en = 0; m1_rd_en = 0; m1_addr = '0; m1_wdata = '0;
        uart_data_ready_int = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
        checkOutput("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
        checkOutput("rst_wr_en", {31'd0, uart_reg_wr_en}, 32'd0);
        checkOutput("rst_rd_en", {31'd0, uart_reg_rd_en}, 32'd0);
        checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
        checkOutput("rst_arb_err", {31'd0, arb_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Interrupt mirror
        uart_data_ready_int = 1'b1;
        #1;
        checkOutput("int_m0_hi", {31'd0, m0_int}, 32'd1);
        checkOutput("int_m1_hi", {31'd0, m1_int}, 32'd1);
        uart_data_ready_int = 1'b0;
        #1;
        checkOutput("int_m0_lo", {31'd0, m0_int}, 32'd0);
        checkOutput("int_m1_lo", {31'd0, m1_int}, 32'd0);
        @(negedge clk);

        // Simultaneous requests x4: last_grant=1 after reset, so each pair is m0 then m1
        respDelay = 2;
        respData  = 32'h5A5A_0002;
        for (int i = 0; i < 4; i++) begin
            issueQ.push_back('{32'h4, 32'h100 + i, 1'b1, 1'b0});
            issueQ.push_back('{32'h0, 32'h200 + i, 1'b1, 1'b0});
            cmpQ.push_back('{1'b0, 32'h5A5A_0002});
            cmpQ.push_back('{1'b1, 32'h5A5A_0002});
            fork
                applyStimulus(1'b0, 1'b1, 1'b0, 32'h4, 32'h100 + i);
                applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h200 + i);
            join
            @(negedge clk);
        end

        // m0 write, uart_ready after 3 cycles; uart en 1 cycle after request
        respDelay = 3;
        respData  = 32'h0000_0077;
        issueQ.push_back('{32'h0, 32'h0002_3C1B, 1'b1, 1'b0});
        cmpQ.push_back('{1'b0, 32'h0000_0077});
        fork
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0002_3C1B);
            begin
                @(negedge clk);
                checkOutput("t1_wr_en_latency", {31'd0, uart_reg_wr_en}, 32'd1);
                checkOutput("t1_rd_en_low", {31'd0, uart_reg_rd_en}, 32'd0);
            end
        join
        checkOutput("t1_m1_ready", {31'd0, m1_ready}, 32'd0);
        @(negedge clk);

        // m1 reads status; m0_rdata keeps its last capture
        respDelay = 1;
        respData  = 32'h0000_0001;
        issueQ.push_back('{32'h8, 32'h0, 1'b0, 1'b1});
        cmpQ.push_back('{1'b1, 32'h0000_0001});
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h8, 32'h0);
        checkOutput("t3_m1_rdata", m1_rdata, 32'h0000_0001);
        checkOutput("t3_m0_rdata_held", m0_rdata, 32'h0000_0077);
        @(negedge clk);

        // wr_en and rd_en together is a write
        respData = 32'h0000_0099;
        issueQ.push_back('{32'h4, 32'h55, 1'b1, 1'b0});
        cmpQ.push_back('{1'b0, 32'h0000_0099});
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h4, 32'h55);
        @(negedge clk);

        // Reset while in ISSUE (last_grant is 0 here, reset must restore 1)
        respDelay = 20;
        issueQ.push_back('{32'h4, 32'hAB, 1'b1, 1'b0});
        m0_wr_en = 1'b1; m0_addr = 32'h4; m0_wdata = 32'hAB;
        repeat (3) @(negedge clk);
        checkOutput("t5_in_issue", {31'd0, uart_reg_wr_en}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_wr_en", {31'd0, uart_reg_wr_en}, 32'd0);
        checkOutput("t5_rst_addr", uart_reg_addr, 32'd0);
        checkOutput("t5_rst_wdata", uart_reg_wdata, 32'd0);
        checkOutput("t5_rst_m0_ready", {31'd0, m0_ready}, 32'd0);
        checkOutput("t5_rst_m0_rdata", m0_rdata, 32'd0);
        checkOutput("t5_rst_m1_rdata", m1_rdata, 32'd0);
        m0_wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        respDelay = 1;
        respData  = 32'h0000_0033;
        issueQ.push_back('{32'h0, 32'h11, 1'b1, 1'b0});
        issueQ.push_back('{32'h4, 32'h22, 1'b1, 1'b0});
        cmpQ.push_back('{1'b0, 32'h0000_0033});
        cmpQ.push_back('{1'b1, 32'h0000_0033});
        fork
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h11);
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h4, 32'h22);
        join
        @(negedge clk);

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: uart never answers
        respDelay = 1000;
        issueQ.push_back('{32'h4, 32'h1, 1'b1, 1'b0});
        cmpQ.push_back('{1'b0, 32'hDEAD_BEEF});
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h4, 32'h1);
        checkOutput("t6_arb_err", {31'd0, arb_err}, 32'd1);
        checkOutput("t6_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
`else
        checkOutput("arb_err_tied", {31'd0, arb_err}, 32'd0);
`endif

        repeat (4) @(negedge clk);
        checkOutput("issue_queue_drained", issueQ.size(), 32'd0);
        checkOutput("cmp_queue_drained", cmpQ.size(), 32'd0);
        checkOutput("end_m0_ready", {31'd0, m0_ready}, 32'd0);
        checkOutput("end_m1_ready", {31'd0, m1_ready}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
